// File: rtl/pe_ctrl_pkg.sv
// Shared types and widths for the PE sequencer: FSM states, counter widths, result payload.
package pe_ctrl_pkg;

    localparam int unsigned MAX_GROUPS  = 16;
    localparam int unsigned MAX_T       = 16;
    localparam int unsigned MAX_NEURONS = 1024;

    localparam int unsigned DATA_W       = 8;
    localparam int unsigned GROUP_W      = $clog2(MAX_GROUPS);
    localparam int unsigned T_W          = $clog2(MAX_T);
    localparam int unsigned NEURON_W     = $clog2(MAX_NEURONS);
    localparam int unsigned GROUP_CFG_W  = GROUP_W + 1;
    localparam int unsigned T_CFG_W      = T_W + 1;
    localparam int unsigned NEURON_CFG_W = NEURON_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_WRITE,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0]   data;
        logic                spike;
        logic [NEURON_W-1:0] neuron;
        logic [T_W-1:0]      t;
    } result_t;

endpackage

// File: rtl/pe_membrane_update.sv
// Spike detection and reset-by-subtraction of the membrane, saturating at zero.
module pe_membrane_update
    import pe_ctrl_pkg::*;
(
    input  logic [DATA_W:0]   i_conv_result,
    input  logic [DATA_W-1:0] i_vth,
    output logic [DATA_W-1:0] o_vmem_c,
    output logic              o_spike_c
);

    logic [DATA_W-1:0] w_integ;

    assign w_integ   = i_conv_result[DATA_W:1];
    assign o_spike_c = i_conv_result[0];

    always_comb begin
        o_vmem_c = w_integ;
        if (o_spike_c) begin
            o_vmem_c = (w_integ > i_vth) ? (w_integ - i_vth) : '0;
        end
    end

endmodule

// File: rtl/pe_sequencer.sv
// Walks neuron -> timestep -> group for one PE, fetches vectors, drains the PE pipe
// and streams out per-timestep membrane/spike (or pooling) results.
module pe_sequencer
    import pe_ctrl_pkg::*;
#(
    parameter int unsigned PE_LATENCY = 3
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    start,
    input  logic                    cfg_mode,
    input  logic [GROUP_CFG_W-1:0]  cfg_groups,
    input  logic [T_CFG_W-1:0]      cfg_timesteps,
    input  logic [NEURON_CFG_W-1:0] cfg_neurons,
    input  logic [DATA_W-1:0]       cfg_vth,
    output logic                    busy,
    output logic                    done,
    output logic                    fetch_req,
    output logic [NEURON_W-1:0]     fetch_neuron,
    output logic [T_W-1:0]          fetch_t,
    output logic [GROUP_W-1:0]      fetch_group,
    input  logic                    fetch_ack,
    output logic                    pe_mode,
    output logic                    pe_accum_src,
    output logic [DATA_W-1:0]       pe_vmem,
    input  logic [DATA_W:0]         pe_conv_result,
    input  logic [DATA_W-1:0]       pe_ap_result,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_spike,
    output logic [NEURON_W-1:0]     out_neuron,
    output logic [T_W-1:0]          out_t
);

    localparam int unsigned DRAIN_W = $clog2(PE_LATENCY + 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_cfg_mode;
    logic [GROUP_CFG_W-1:0]  r_cfg_groups;
    logic [T_CFG_W-1:0]      r_cfg_timesteps;
    logic [NEURON_CFG_W-1:0] r_cfg_neurons;
    logic [DATA_W-1:0]       r_cfg_vth;
    logic [NEURON_W-1:0]     r_n;
    logic [T_W-1:0]          r_t;
    logic [GROUP_W-1:0]      r_g;
    logic [DRAIN_W-1:0]      r_drain;
    logic [DRAIN_W-1:0]      w_drain_dec;
    logic [DATA_W-1:0]       r_membrane;
    result_t                 r_result;
    logic                    w_last_group;
    logic                    w_last_t;
    logic                    w_last_n;
    logic [DATA_W-1:0]       w_new_vmem;
    logic                    w_spike;

    pe_membrane_update u_membrane_update (
        .i_conv_result (pe_conv_result),
        .i_vth         (r_cfg_vth),
        .o_vmem_c      (w_new_vmem),
        .o_spike_c     (w_spike)
    );

    assign w_last_group = (GROUP_CFG_W'(r_g) == r_cfg_groups - GROUP_CFG_W'(1));
    assign w_last_t     = (T_CFG_W'(r_t) == r_cfg_timesteps - T_CFG_W'(1));
    assign w_last_n     = (NEURON_CFG_W'(r_n) == r_cfg_neurons - NEURON_CFG_W'(1));
    assign w_drain_dec  = r_drain - DRAIN_W'(1);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_FETCH;
            ST_FETCH: if (fetch_ack && w_last_group) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_drain_dec == '0) w_state_nxt = ST_WRITE;
            ST_WRITE: if (out_ready) w_state_nxt = (w_last_t && w_last_n) ? ST_DONE : ST_FETCH;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Loop counters, latched config, drain timer, membrane and result capture
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cfg_mode      <= 1'b0;
            r_cfg_groups    <= '0;
            r_cfg_timesteps <= '0;
            r_cfg_neurons   <= '0;
            r_cfg_vth       <= '0;
            r_n             <= '0;
            r_t             <= '0;
            r_g             <= '0;
            r_drain         <= '0;
            r_membrane      <= '0;
            r_result        <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_cfg_mode      <= cfg_mode;
                        r_cfg_groups    <= cfg_groups;
                        r_cfg_timesteps <= cfg_timesteps;
                        r_cfg_neurons   <= cfg_neurons;
                        r_cfg_vth       <= cfg_vth;
                        r_n             <= '0;
                        r_t             <= '0;
                        r_g             <= '0;
                        r_membrane      <= '0;
                    end
                end
                ST_FETCH: begin
                    if (fetch_ack) begin
                        if (!w_last_group) r_g     <= r_g + GROUP_W'(1);
                        else               r_drain <= DRAIN_W'(PE_LATENCY);
                    end
                end
                ST_DRAIN: begin
                    r_drain <= w_drain_dec;
                    if (w_drain_dec == '0) begin
                        r_result.data   <= r_cfg_mode ? pe_ap_result : w_new_vmem;
                        r_result.spike  <= w_spike & ~r_cfg_mode;
                        r_result.neuron <= r_n;
                        r_result.t      <= r_t;
                        if (!r_cfg_mode) r_membrane <= w_new_vmem;
                    end
                end
                ST_WRITE: begin
                    if (out_ready) begin
                        if (!w_last_t) begin
                            r_t <= r_t + T_W'(1);
                            r_g <= '0;
                        end else if (!w_last_n) begin
                            r_n        <= r_n + NEURON_W'(1);
                            r_t        <= '0;
                            r_g        <= '0;
                            r_membrane <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy         = (r_state == ST_FETCH) || (r_state == ST_DRAIN) || (r_state == ST_WRITE);
    assign done         = (r_state == ST_DONE);
    assign fetch_req    = (r_state == ST_FETCH);
    assign fetch_neuron = r_n;
    assign fetch_t      = r_t;
    assign fetch_group  = r_g;
    assign pe_mode      = r_cfg_mode;
    // Group 0 of each timestep seeds the PE accumulator from the stored membrane
    assign pe_accum_src = (r_state == ST_FETCH) && fetch_ack && (r_g == '0);
    assign pe_vmem      = r_cfg_mode ? '0 : r_membrane;
    assign out_valid    = (r_state == ST_WRITE);
    assign out_data     = r_result.data;
    assign out_spike    = r_result.spike;
    assign out_neuron   = r_result.neuron;
    assign out_t        = r_result.t;

endmodule
